// File: rtl/result_unpacker_256_if.sv
// rtl/result_unpacker_256_if.sv - result-BRAM read port and packed output stream of the result unpacker
interface result_unpacker_256_if;
    logic        rd_en;
    logic [9:0]  rd_addr;
    logic [15:0] rd_data;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_data;
    logic        out_last;

    modport master (
        output rd_en, rd_addr, out_valid, out_data, out_last,
        input  rd_data, out_ready
    );

    modport slave (
        input  rd_en, rd_addr, out_valid, out_data, out_last,
        output rd_data, out_ready
    );
endinterface

// File: rtl/result_unpacker_256.sv
// rtl/result_unpacker_256.sv - reads 16-bit result coefficients from BRAM and packs four per 64-bit stream word
// NEGACYCLIC_REDUCE_EN: emit c[i]-c[i+256] as 64 words instead of raw c[0..511] as 128 words
module result_unpacker_256 (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    result_unpacker_256_if.master bus
);
`ifdef NEGACYCLIC_REDUCE_EN
    localparam int         PW        = 3;
    localparam logic [6:0] LAST_WORD = 7'd63;
`else
    localparam int         PW        = 2;
    localparam logic [6:0] LAST_WORD = 7'd127;
`endif

    typedef enum logic [1:0] {IDLE, READ, DRAIN, HOLD} state_t;

    state_t         state;
    logic [8:0]     rcnt;
    logic [6:0]     wcnt;
    logic           pending;
    logic           cap_en;
    logic [PW-1:0]  cap_pos;
    logic [63:0]    acc;
    logic [63:0]    acc_next;
    logic           rd_en_r;
    logic [9:0]     rd_addr_r;
    logic           out_valid_r;
    logic           out_last_r;
    logic [63:0]    out_data_r;
`ifdef NEGACYCLIC_REDUCE_EN
    logic [15:0]    lo;
`endif

    // Read counter to BRAM address; in reduce mode bit 0 selects the upper-half partner
    function automatic logic [9:0] addr_of(input logic [8:0] cnt);
        logic [8:0] idx;
`ifdef NEGACYCLIC_REDUCE_EN
        idx = {cnt[0], cnt[8:1]};
`else
        idx = cnt;
`endif
        return {1'b1, idx[8], idx[5:0], idx[7:6]};
    endfunction

    logic word_end, hs, out_free, last_word;
    assign word_end  = &rcnt[PW-1:0];
    assign hs        = out_valid_r & bus.out_ready;
    assign out_free  = ~out_valid_r | hs;
    assign last_word = (wcnt == LAST_WORD);

    assign bus.rd_en     = rd_en_r;
    assign bus.rd_addr   = rd_addr_r;
    assign bus.out_valid = out_valid_r;
    assign bus.out_data  = out_data_r;
    assign bus.out_last  = out_last_r;

    // Word being assembled including the coefficient arriving this cycle
    always_comb begin
        acc_next = acc;
        if (cap_en) begin
`ifdef NEGACYCLIC_REDUCE_EN
            if (cap_pos[0])
                acc_next[{cap_pos[2:1], 4'b0} +: 16] = lo - bus.rd_data;
`else
            acc_next[{cap_pos, 4'b0} +: 16] = bus.rd_data;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state       <= IDLE;
            busy        <= 1'b0;
            done        <= 1'b0;
            rcnt        <= '0;
            wcnt        <= '0;
            pending     <= 1'b0;
            cap_en      <= 1'b0;
            cap_pos     <= '0;
            acc         <= '0;
            rd_en_r     <= 1'b0;
            rd_addr_r   <= '0;
            out_valid_r <= 1'b0;
            out_last_r  <= 1'b0;
            out_data_r  <= '0;
`ifdef NEGACYCLIC_REDUCE_EN
            lo          <= '0;
`endif
        end else begin
            done    <= 1'b0;
            cap_en  <= rd_en_r;
            cap_pos <= rcnt[PW-1:0];
            acc     <= acc_next;
`ifdef NEGACYCLIC_REDUCE_EN
            if (cap_en && !cap_pos[0])
                lo <= bus.rd_data;
`endif
            if (hs) begin
                out_valid_r <= 1'b0;
                out_last_r  <= 1'b0;
            end
            case (state)
                IDLE: begin
                    if (start) begin
                        state     <= READ;
                        busy      <= 1'b1;
                        rcnt      <= '0;
                        wcnt      <= '0;
                        pending   <= 1'b0;
                        rd_en_r   <= 1'b1;
                        rd_addr_r <= addr_of(9'd0);
                    end
                end
                READ: begin
                    rcnt <= rcnt + 9'd1;
                    if (word_end) begin
                        state   <= DRAIN;
                        rd_en_r <= 1'b0;
                    end else begin
                        rd_addr_r <= addr_of(rcnt + 9'd1);
                    end
                end
                DRAIN: begin
                    if (out_free) begin
                        out_valid_r <= 1'b1;
                        out_data_r  <= acc_next;
                        out_last_r  <= last_word;
                        wcnt        <= wcnt + 7'd1;
                        if (last_word) begin
                            state <= HOLD;
                        end else begin
                            state     <= READ;
                            rd_en_r   <= 1'b1;
                            rd_addr_r <= addr_of(rcnt);
                        end
                    end else begin
                        state   <= HOLD;
                        pending <= 1'b1;
                    end
                end
                HOLD: begin
                    if (hs) begin
                        if (pending) begin
                            pending     <= 1'b0;
                            out_valid_r <= 1'b1;
                            out_data_r  <= acc;
                            out_last_r  <= last_word;
                            wcnt        <= wcnt + 7'd1;
                            if (!last_word) begin
                                state     <= READ;
                                rd_en_r   <= 1'b1;
                                rd_addr_r <= addr_of(rcnt);
                            end
                        end else begin
                            // handshake of the final word closes the stream
                            state <= IDLE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
